// File: rtl/udp_order_tx_if.sv
// Order request handshake plus byte-wide AXI-Stream toward the MAC.
// The framer uses the master view; the order source / MAC side uses slave.
interface udp_order_tx_if;
  logic        order_valid;
  logic        order_ready;
  logic [31:0] order_symbol;
  logic [31:0] order_price;
  logic [15:0] order_qty;
  logic [7:0]  order_side;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;

  modport master (
    input  order_valid, order_symbol, order_price, order_qty, order_side,
    output order_ready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    output order_valid, order_symbol, order_price, order_qty, order_side,
    input  order_ready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/udp_order_tx.sv
// Serializes one order into a 54-byte Ethernet/IPv4/UDP frame on a byte stream.
// The IPv4 checksum is recomputed per frame since the identification field changes.
module udp_order_tx #(
  parameter logic [47:0] SRC_MAC  = 48'h02_00_00_00_00_01,
  parameter logic [47:0] DST_MAC  = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [31:0] SRC_IP   = 32'hC0A8_0001,
  parameter logic [31:0] DST_IP   = 32'hC0A8_0002,
  parameter logic [15:0] SRC_PORT = 16'd5000,
  parameter logic [15:0] DST_PORT = 16'd6000,
  parameter logic [7:0]  TTL      = 8'd64
) (
  input  logic               clk,
  input  logic               rst_n,
  udp_order_tx_if.master     bus,
  output logic [15:0]        frame_count,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, CSUM, SEND} state_t;

  localparam logic [5:0] LAST_IDX = 6'd53;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] sym_q;
  logic [31:0] price_q;
  logic [15:0] qty_q;
  logic [7:0]  side_q;
  logic [15:0] id_q;
  logic [15:0] ip_id;
  logic [15:0] csum_q;
  logic [5:0]  idx;
  logic [7:0]  frame_byte;
  logic        accept;
  logic        hs;
  logic        last_hs;
  logic [31:0] csum_sum;
  logic [16:0] csum_fold1;
  logic [15:0] csum_fold2;

  assign accept  = bus.order_valid && (state == IDLE);
  assign hs      = (state == SEND) && bus.m_axis_tready;
  assign last_hs = hs && (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CSUM;
      CSUM:    state_nxt = SEND;
      SEND:    if (last_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.order_ready   = (state == IDLE);
    busy              = (state != IDLE);
    bus.m_axis_tvalid = (state == SEND);
    bus.m_axis_tlast  = (state == SEND) && (idx == LAST_IDX);
    bus.m_axis_tdata  = (state == SEND) ? frame_byte : 8'h00;
  end

  // Header words with the checksum field as zero; two folds absorb every carry.
  always_comb begin
    csum_sum = 32'h0000_4500 + 32'h0000_0028 + {16'h0000, id_q} + 32'h0000_4000
             + {16'h0000, TTL, 8'h11}
             + {16'h0000, SRC_IP[31:16]} + {16'h0000, SRC_IP[15:0]}
             + {16'h0000, DST_IP[31:16]} + {16'h0000, DST_IP[15:0]};
    csum_fold1 = {1'b0, csum_sum[15:0]} + {1'b0, csum_sum[31:16]};
    csum_fold2 = csum_fold1[15:0] + {15'd0, csum_fold1[16]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_q       <= '0;
      price_q     <= '0;
      qty_q       <= '0;
      side_q      <= '0;
      id_q        <= '0;
      ip_id       <= '0;
      csum_q      <= '0;
      idx         <= '0;
      frame_count <= '0;
    end else begin
      if (accept) begin
        sym_q   <= bus.order_symbol;
        price_q <= bus.order_price;
        qty_q   <= bus.order_qty;
        side_q  <= bus.order_side;
        id_q    <= ip_id;
      end
      if (state == CSUM) begin
        csum_q <= ~csum_fold2;
        idx    <= '0;
      end else if (hs && (idx != LAST_IDX)) begin
        idx <= idx + 6'd1;
      end
      if (last_hs) begin
        ip_id       <= ip_id + 16'd1;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  // Bytes not listed (TOS, flags low byte, UDP checksum, ...) are zero.
  always_comb begin
    frame_byte = 8'h00;
    case (idx)
      6'd0:  frame_byte = DST_MAC[47:40];
      6'd1:  frame_byte = DST_MAC[39:32];
      6'd2:  frame_byte = DST_MAC[31:24];
      6'd3:  frame_byte = DST_MAC[23:16];
      6'd4:  frame_byte = DST_MAC[15:8];
      6'd5:  frame_byte = DST_MAC[7:0];
      6'd6:  frame_byte = SRC_MAC[47:40];
      6'd7:  frame_byte = SRC_MAC[39:32];
      6'd8:  frame_byte = SRC_MAC[31:24];
      6'd9:  frame_byte = SRC_MAC[23:16];
      6'd10: frame_byte = SRC_MAC[15:8];
      6'd11: frame_byte = SRC_MAC[7:0];
      6'd12: frame_byte = 8'h08;
      6'd14: frame_byte = 8'h45;
      6'd17: frame_byte = 8'h28;
      6'd18: frame_byte = id_q[15:8];
      6'd19: frame_byte = id_q[7:0];
      6'd20: frame_byte = 8'h40;
      6'd22: frame_byte = TTL;
      6'd23: frame_byte = 8'h11;
      6'd24: frame_byte = csum_q[15:8];
      6'd25: frame_byte = csum_q[7:0];
      6'd26: frame_byte = SRC_IP[31:24];
      6'd27: frame_byte = SRC_IP[23:16];
      6'd28: frame_byte = SRC_IP[15:8];
      6'd29: frame_byte = SRC_IP[7:0];
      6'd30: frame_byte = DST_IP[31:24];
      6'd31: frame_byte = DST_IP[23:16];
      6'd32: frame_byte = DST_IP[15:8];
      6'd33: frame_byte = DST_IP[7:0];
      6'd34: frame_byte = SRC_PORT[15:8];
      6'd35: frame_byte = SRC_PORT[7:0];
      6'd36: frame_byte = DST_PORT[15:8];
      6'd37: frame_byte = DST_PORT[7:0];
      6'd39: frame_byte = 8'h14;
      6'd42: frame_byte = sym_q[31:24];
      6'd43: frame_byte = sym_q[23:16];
      6'd44: frame_byte = sym_q[15:8];
      6'd45: frame_byte = sym_q[7:0];
      6'd46: frame_byte = price_q[31:24];
      6'd47: frame_byte = price_q[23:16];
      6'd48: frame_byte = price_q[15:8];
      6'd49: frame_byte = price_q[7:0];
      6'd50: frame_byte = qty_q[15:8];
      6'd51: frame_byte = qty_q[7:0];
      6'd52: frame_byte = side_q;
      6'd53: frame_byte = id_q[7:0];
      default: frame_byte = 8'h00;
    endcase
  end

endmodule
